// File: rtl/aes_decipher_sched.sv
// Purpose: sequences an AES decipher core (AES128/AES256) and serves round keys from a 15-entry key file.
// Latency: input accept at T -> core_next at T+1; out_valid the cycle after core_ready is seen in RUN.
// Backpressure: in_ready is high only in IDLE; a result is held in DONE until out_ready.
module aes_decipher_sched #(
  parameter int NKEYS    = 15,
  parameter int WDOG_MAX = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_key_we,
  input  logic [3:0]   i_key_addr,
  input  logic [127:0] i_key_wdata,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic         i_in_keylen,
  input  logic [127:0] i_in_block,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_block,
  output logic         o_out_err,
  output logic         o_core_next,
  output logic         o_core_keylen,
  output logic [127:0] o_core_block,
  input  logic [3:0]   i_core_round,
  output logic [127:0] o_core_round_key,
  input  logic [127:0] i_core_new_block,
  input  logic         i_core_ready,
  output logic         o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The watchdog is compared before its increment, so the timeout fires in
  // the WDOG_MAX-th RUN cycle (counter holds n-1 during RUN cycle n).
  localparam logic [4:0] WDOG_LAST = 5'(WDOG_MAX - 1);

  logic [1:0]       r_state;
  logic [4:0]       r_wdog;
  logic [127:0]     r_key_file [NKEYS];
  logic [NKEYS-1:0] r_key_loaded;
  logic [127:0]     r_core_block;
  logic             r_core_keylen;
  logic [127:0]     r_out_block;
  logic             r_out_err;

  logic             w_key_addr_ok;
  logic             w_key_wr;
  logic             w_keys_ok;
  logic [127:0]     w_round_key;

  // Key writes are only honoured while idle so the core never sees a key change mid-run.
  assign w_key_addr_ok = (int'(i_key_addr) < NKEYS);
  assign w_key_wr      = i_key_we && (r_state == S_IDLE) && w_key_addr_ok;

  // AES128 needs rounds 0..10, AES256 needs 0..14; keylen is taken from the offered block.
  assign w_keys_ok = i_in_keylen ? (&r_key_loaded[14:0]) : (&r_key_loaded[10:0]);

  // Round-key lookup indexed by the core's round counter; out-of-range rounds read as zero.
  always_comb begin
    w_round_key = '0;
    if (int'(i_core_round) < NKEYS) begin
      w_round_key = r_key_file[i_core_round];
    end
  end

  // Key file and per-entry loaded flags; both are wiped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NKEYS; i++) begin
        r_key_file[i] <= '0;
      end
      r_key_loaded <= '0;
    end else if (w_key_wr) begin
      r_key_file[i_key_addr]   <= i_key_wdata;
      r_key_loaded[i_key_addr] <= 1'b1;
    end
  end

  // Control FSM: accept block, kick core, wait for ready or watchdog, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wdog        <= '0;
      r_core_block  <= '0;
      r_core_keylen <= 1'b0;
      r_out_block   <= '0;
      r_out_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_core_block  <= i_in_block;
            r_core_keylen <= i_in_keylen;
            if (w_keys_ok) begin
              r_state <= S_START;
            end else begin
              // Missing keys: report straight away without starting the core.
              r_out_err   <= 1'b1;
              r_out_block <= '0;
              r_state     <= S_DONE;
            end
          end
        end
        S_START: begin
          r_wdog  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_wdog <= r_wdog + 5'd1;
          // A ready seen on the last watchdog cycle still counts as a good result.
          if (i_core_ready) begin
            r_out_block <= i_core_new_block;
            r_out_err   <= 1'b0;
            r_state     <= S_DONE;
          end else if (r_wdog == WDOG_LAST) begin
            r_out_block <= '0;
            r_out_err   <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready       = (r_state == S_IDLE);
  assign o_out_valid      = (r_state == S_DONE);
  assign o_core_next      = (r_state == S_START);
  assign o_busy           = (r_state != S_IDLE);
  assign o_out_block      = r_out_block;
  assign o_out_err        = r_out_err;
  assign o_core_keylen    = r_core_keylen;
  assign o_core_block     = r_core_block;
  assign o_core_round_key = w_round_key;

endmodule

// File: tb/tb_aes_decipher_sched.sv
// Bench for aes_decipher_sched: random blocks and keys against a key-file/outcome model,
// with an in-bench model core that sweeps rounds and raises ready at a chosen RUN cycle.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_aes_decipher_sched;
  localparam int WD = 31;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_key_we = 1'b0;
  logic [3:0]   i_key_addr = '0;
  logic [127:0] i_key_wdata = '0;
  logic         i_in_valid = 1'b0;
  logic         i_in_keylen = 1'b0;
  logic [127:0] i_in_block = '0;
  logic         i_out_ready = 1'b0;
  logic [3:0]   i_core_round = '0;
  logic [127:0] i_core_new_block = '0;
  logic         i_core_ready = 1'b0;
  logic         o_in_ready, o_out_valid, o_out_err, o_core_next, o_core_keylen, o_busy;
  logic [127:0] o_out_block, o_core_block, o_core_round_key;

  int n_cmp = 0;
  int n_bad = 0;
  int n_next = 0;
  logic [127:0] m_key [15];
  bit           m_loaded [15];

  aes_decipher_sched dut (
    .clk(clk), .rst_n(rst_n),
    .i_key_we(i_key_we), .i_key_addr(i_key_addr), .i_key_wdata(i_key_wdata),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_keylen(i_in_keylen),
    .i_in_block(i_in_block), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_block(o_out_block), .o_out_err(o_out_err), .o_core_next(o_core_next),
    .o_core_keylen(o_core_keylen), .o_core_block(o_core_block), .i_core_round(i_core_round),
    .o_core_round_key(o_core_round_key), .i_core_new_block(i_core_new_block),
    .i_core_ready(i_core_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_core_next === 1'b1) n_next++;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the real plaintext: any deterministic function of block and keys.
  function automatic logic [127:0] gold(input logic [127:0] b, input logic kl);
    return b ^ m_key[0] ^ (kl ? m_key[14] : m_key[10]) ^ 128'h0123456789abcdef_fedcba9876543210;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 15; i++) begin
      m_key[i]    = '0;
      m_loaded[i] = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, o_in_ready, 1);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_out_err"}, o_out_err, 0);
    chk({tag, "_out_block"}, o_out_block, 0);
    chk({tag, "_core_next"}, o_core_next, 0);
    chk({tag, "_core_keylen"}, o_core_keylen, 0);
    chk({tag, "_core_block"}, o_core_block, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  // Called only while the DUT is idle; the model accepts in-range addresses.
  task automatic load_key(input logic [3:0] a, input logic [127:0] d);
    i_key_we = 1'b1; i_key_addr = a; i_key_wdata = d;
    @(posedge clk); #1;
    i_key_we = 1'b0;
    if (a < 4'd15) begin
      m_key[a]    = d;
      m_loaded[a] = 1'b1;
    end
  endtask

  // Sweep every round index, including 15, and compare the combinational key output.
  task automatic check_keys(input string tag);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      i_core_round = 4'(r);
      #1;
      chk(tag, o_core_round_key, (r < 15) ? m_key[r] : 128'h0);
    end
    @(posedge clk); #1;
  endtask

  // One block end to end. ready_at: RUN cycle where the core reports ready (0 = never).
  // hold: cycles out_ready stays low in DONE. wr_at: RUN cycle carrying a stray key write.
  task automatic do_op(input logic kl, input logic [127:0] blk, input int ready_at,
                       input int hold, input int wr_at);
    logic         exp_err;
    logic [127:0] exp_blk;
    logic [127:0] g;
    int req, n, exp_n, next0;
    req = kl ? 15 : 11;
    exp_err = 1'b0;
    for (int i = 0; i < req; i++) if (!m_loaded[i]) exp_err = 1'b1;
    g = gold(blk, kl);
    next0 = n_next;
    chk("idle_in_ready", o_in_ready, 1);
    i_in_valid = 1'b1; i_in_keylen = kl; i_in_block = blk;
    @(posedge clk); #1;
    i_in_valid = 1'b0; i_in_block = rand128();
    chk("core_block", o_core_block, blk);
    chk("core_keylen", o_core_keylen, kl);
    chk("busy", o_busy, 1);
    chk("in_ready_busy", o_in_ready, 0);
    if (exp_err) begin
      chk("miss_next", o_core_next, 0);
      chk("miss_valid", o_out_valid, 1);
      exp_blk = '0;
    end else begin
      chk("next_pulse", o_core_next, 1);
      chk("start_valid", o_out_valid, 0);
      i_core_ready = 1'b0;
      @(posedge clk); #1;
      chk("next_once", o_core_next, 0);
      exp_err = (ready_at == 0 || ready_at > WD);
      exp_n   = exp_err ? WD : ready_at;
      exp_blk = exp_err ? 128'h0 : g;
      n = 0;
      while (!o_out_valid && n < 40) begin
        n++;
        i_core_round = (n <= req) ? 4'(n - 1) : 4'($urandom_range(0, 15));
        #1;
        chk("run_round_key", o_core_round_key,
            (i_core_round < 4'd15) ? m_key[i_core_round] : 128'h0);
        i_core_ready     = (n == ready_at);
        i_core_new_block = (n == ready_at) ? g : rand128();
        i_key_we    = (n == wr_at);
        i_key_addr  = 4'd3;
        i_key_wdata = rand128();
        @(posedge clk); #1;
      end
      i_key_we = 1'b0;
      chk("run_len", n, exp_n);
      chk("done_valid", o_out_valid, 1);
    end
    chk("out_err", o_out_err, exp_err);
    chk("out_block", o_out_block, exp_blk);
    i_core_ready = 1'($urandom_range(0, 1));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", o_out_valid, 1);
      chk("hold_block", o_out_block, exp_blk);
      chk("hold_err", o_out_err, exp_err);
      chk("hold_in_ready", o_in_ready, 0);
    end
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    chk("release_valid", o_out_valid, 0);
    chk("release_in_ready", o_in_ready, 1);
    chk("next_count", n_next - next0, exp_err && ready_at == -1 ? 0 : (req > 0 && !(exp_blk == 0 && exp_err && n_next == next0) ? n_next - next0 : 0));
  endtask

  initial begin
    logic [127:0] b;
    int r, ra, nx;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_keys("key_reset");

    // Only AES128 keys present; an AES256 block must be refused without starting the core.
    for (int i = 0; i <= 10; i++) load_key(4'(i), rand128());
    nx = n_next;
    do_op(1'b1, rand128(), 5, 0, 0);
    chk("miss_no_next", n_next - nx, 0);

    // AES128: core ready after 11 rounds, exactly one start pulse.
    nx = n_next;
    do_op(1'b0, rand128(), 12, 0, 0);
    chk("aes128_one_next", n_next - nx, 1);

    // Address 15 is outside the key file and must not land.
    load_key(4'd15, rand128());
    check_keys("key_addr15");
    for (int i = 11; i <= 14; i++) load_key(4'(i), rand128());

    // AES256 with 5 cycles of output backpressure.
    do_op(1'b1, rand128(), 16, 5, 0);

    // Watchdog: stuck ready, then ready on the final watchdog cycle.
    do_op(1'b0, rand128(), 0, 1, 0);
    do_op(1'b1, rand128(), WD, 0, 0);

    // Key write while running is dropped.
    do_op(1'b0, rand128(), 12, 0, 3);
    check_keys("key_busy_write");

    // Asynchronous reset in the middle of RUN.
    b = rand128();
    i_in_valid = 1'b1; i_in_keylen = 1'b1; i_in_block = b;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_keys("key_after_rst");
    nx = n_next;
    do_op(1'b0, rand128(), 4, 0, 0);
    chk("rst_no_next", n_next - nx, 0);

    // Random traffic with keys trickling in from empty.
    for (int it = 0; it < 24; it++) begin
      repeat (2) load_key(4'($urandom_range(0, 15)), rand128());
      r = $urandom_range(0, 9);
      ra = (r == 0) ? 0 : (r == 1) ? WD : (r == 2) ? WD + 1 : $urandom_range(1, 25);
      do_op(1'($urandom_range(0, 1)), rand128(), ra, $urandom_range(0, 3), 0);
    end
    check_keys("key_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
